// File: rtl/frame_pkg.sv
// Shared constants and types for the response-frame serializer.
package frame_pkg;
  localparam int FRAME_W     = 160;
  localparam int FRAME_BYTES = FRAME_W / 8;
  localparam int IDX_W       = $clog2(FRAME_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_LATCH, S_ARM, S_START, S_WAIT_TX, S_DONE, S_ABORT
  } state_t;
endpackage

// File: rtl/frame_serializer.sv
// Pops frames from the data-back fifo and streams them byte-by-byte into the uart tx handshake.
// Build option: FRAME_SERIALIZER_CKSUM_EN appends an XOR checksum byte after the data bytes.
module frame_serializer
  import frame_pkg::*;
#(
  parameter int FRAME_W     = frame_pkg::FRAME_W,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int ACK_TIMEOUT = 1023
)(
  input  logic               clk40,
  input  logic               reset,
  input  logic               data_back_fifo_empty,
  output logic               data_back_fifo_rd,
  input  logic [FRAME_W-1:0] data_back,
  input  logic               send_ready,
  output logic               start_send,
  output logic [7:0]         data_send,
  output logic               busy,
  output logic               tx_timeout,
  output logic [15:0]        frame_count
);
  localparam int NBYTES = FRAME_W / 8;
  localparam int IW     = $clog2(NBYTES + 1);
  localparam int TW     = $clog2(ACK_TIMEOUT + 1);
`ifdef FRAME_SERIALIZER_CKSUM_EN
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES);
`else
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
`endif
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

  state_t             r_state, w_next;
  logic [FRAME_W-1:0] r_shift;
  logic [IW-1:0]      r_idx;
  logic [TW-1:0]      r_to_cnt;
  logic [15:0]        r_frame_count;
  logic [7:0]         w_byte, w_cur;
  logic               w_timeout_hit;

  assign w_timeout_hit = (r_to_cnt == TO_LAST);
  assign w_byte        = MSB_FIRST ? r_shift[FRAME_W-1 -: 8] : r_shift[7:0];
  assign frame_count   = r_frame_count;

`ifdef FRAME_SERIALIZER_CKSUM_EN
  logic [7:0] r_cksum, w_xor;

  always_comb begin
    w_xor = 8'h00;
    for (int i = 0; i < NBYTES; i++) w_xor = w_xor ^ data_back[8*i +: 8];
  end

  always_ff @(posedge clk40) begin
    if (reset)                  r_cksum <= 8'h00;
    else if (r_state == S_LATCH) r_cksum <= w_xor;
  end

  // Once all data bytes are shifted out the index points at the checksum slot.
  assign w_cur = (r_idx == IW'(NBYTES)) ? r_cksum : w_byte;
`else
  assign w_cur = w_byte;
`endif

  always_ff @(posedge clk40) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (!data_back_fifo_empty) w_next = S_POP;
      S_POP:     w_next = S_LATCH;
      S_LATCH:   w_next = S_ARM;
      S_ARM:     if (send_ready) w_next = S_START;
      S_START: begin
        if (!send_ready)        w_next = S_WAIT_TX;
        else if (w_timeout_hit) w_next = S_ABORT;
      end
      S_WAIT_TX: if (send_ready) w_next = (r_idx == LAST_IDX) ? S_DONE : S_ARM;
      S_DONE:    w_next = S_IDLE;
      S_ABORT:   w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is high so start_send drops in the reset cycle itself.
  always_comb begin
    data_back_fifo_rd = 1'b0;
    start_send        = 1'b0;
    busy              = 1'b0;
    tx_timeout        = 1'b0;
    data_send         = 8'h00;
    if (!reset) begin
      case (r_state)
        S_POP:   data_back_fifo_rd = 1'b1;
        S_LATCH: busy = 1'b1;
        S_ARM, S_WAIT_TX: begin
          busy      = 1'b1;
          data_send = w_cur;
        end
        S_START: begin
          busy       = 1'b1;
          start_send = 1'b1;
          data_send  = w_cur;
        end
        S_ABORT: tx_timeout = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk40) begin
    if (reset) begin
      r_shift       <= '0;
      r_idx         <= '0;
      r_to_cnt      <= '0;
      r_frame_count <= 16'h0000;
    end else begin
      if (r_state == S_START) r_to_cnt <= r_to_cnt + TW'(1);
      else                    r_to_cnt <= '0;
      case (r_state)
        S_IDLE:  r_idx <= '0;
        S_LATCH: begin
          r_shift <= data_back;
          r_idx   <= '0;
        end
        S_WAIT_TX: if (send_ready) begin
          r_idx   <= r_idx + IW'(1);
          r_shift <= MSB_FIRST ? (r_shift << 8) : (r_shift >> 8);
        end
        S_DONE:  r_frame_count <= r_frame_count + 16'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_serializer.sv
// Randomized bench: fifo + uart models drive the serializer, a byte scoreboard checks the wire.
module tb_frame_serializer;
  import frame_pkg::*;
  localparam int FW     = FRAME_W;
  localparam int NB     = FRAME_BYTES;
  localparam int ACK_TO = 1023;
`ifdef FRAME_SERIALIZER_CKSUM_EN
  localparam int WIRE_B = NB + 1;
`else
  localparam int WIRE_B = NB;
`endif

  logic          clk40 = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd;
  logic [FW-1:0] data_back = '0;
  logic          send_ready = 1'b1;
  logic          start_send, busy, tx_timeout;
  logic [7:0]    data_send;
  logic [15:0]   frame_count;

  int n_cmp = 0, n_err = 0;
  int n_rd = 0, n_to = 0, cyc = 0, pop_cyc = 0, run = 0;
  bit lat_pend = 1'b0, uart_mute = 1'b0, rand_mode = 1'b0;
  logic prev_ss = 1'b0;
  logic [15:0] model_cnt = 16'h0000;

  logic [FW-1:0] fifo_q[$];
  logic [7:0]    exp_q[$];
  logic [7:0]    log_q[$];

  always #5 clk40 = ~clk40;

  frame_serializer dut (
    .clk40(clk40), .reset(reset),
    .data_back_fifo_empty(fifo_empty), .data_back_fifo_rd(fifo_rd), .data_back(data_back),
    .send_ready(send_ready), .start_send(start_send), .data_send(data_send),
    .busy(busy), .tx_timeout(tx_timeout), .frame_count(frame_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wire image of a frame: MSB-first bytes, plus XOR byte when the checksum is built in.
  function automatic void push_exp(input logic [FW-1:0] f);
    logic [7:0] x, b;
    x = 8'h00;
    for (int i = 0; i < NB; i++) begin
      b = f[FW-1-8*i -: 8];
      exp_q.push_back(b);
      x = x ^ b;
    end
`ifdef FRAME_SERIALIZER_CKSUM_EN
    exp_q.push_back(x);
`endif
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int i = 0; i < FW/32; i++) f[32*i +: 32] = $urandom();
    return f;
  endfunction

  // fifo_160bit, standard mode: dout valid the cycle after rd_en.
  initial begin : fifo_model
    forever begin
      @(posedge clk40);
      if (fifo_rd && fifo_q.size() > 0) begin
        data_back <= fifo_q[0];
        push_exp(fifo_q[0]);
        fifo_q.delete(0);
      end
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // uart_top tx: edge-triggered start, ready drops after ack cycles, returns after the byte time.
  initial begin : uart_model
    logic prev;
    logic [7:0] b;
    int ack, bsy;
    prev = 1'b0;
    forever begin
      @(negedge clk40);
      if (start_send && !prev && !uart_mute && !reset) begin
        b = data_send;
        log_q.push_back(b);
        ack = rand_mode ? $urandom_range(1, 4) : 3;
        bsy = rand_mode ? $urandom_range(1, 6) : 4;
        check("byte_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("byte", b, exp_q[0]);
          exp_q.delete(0);
          if (exp_q.size() == 0) model_cnt = model_cnt + 16'd1;
        end
        repeat (ack - 1) begin
          @(negedge clk40);
          if (!reset && busy) check("tx_hold", {start_send, data_send}, {1'b1, b});
        end
        send_ready = 1'b0;
        repeat (bsy) begin
          @(negedge clk40);
          if (!reset && busy) check("tx_stable", {start_send, data_send}, {1'b0, b});
        end
        send_ready = 1'b1;
      end
      prev = start_send;
    end
  end

  // Per-cycle protocol checks.
  initial begin : compare
    forever begin
      @(negedge clk40);
      cyc++;
      if (reset) lat_pend = 1'b0;
      else begin
        if (fifo_rd) begin
          n_rd++;
          check("rd_while_empty", fifo_empty, 0);
          check("rd_while_busy", busy, 0);
          pop_cyc  = cyc;
          lat_pend = 1'b1;
        end
        if (start_send) begin
          check("busy_during_start", busy, 1);
          if (!prev_ss) begin
            run = 1;
            if (lat_pend) begin
              check("pop_to_start", cyc - pop_cyc, 3);
              lat_pend = 1'b0;
            end
          end else run++;
        end
        if (tx_timeout) begin
          n_to++;
          check("timeout_expected", uart_mute, 1);
          check("timeout_len", run, ACK_TO);
          check("timeout_ss_low", start_send, 0);
          exp_q.delete();
        end
      end
      prev_ss = start_send;
    end
  end

  task automatic wait_quiet(input string tag);
    int q, c;
    q = 0; c = 0;
    while (q < 6 && c < 20000) begin
      @(negedge clk40);
      c++;
      if (fifo_q.size() == 0 && exp_q.size() == 0 && fifo_empty && !busy && !start_send && send_ready)
        q++;
      else q = 0;
    end
    if (c >= 20000) check({"quiet_budget_", tag}, c, 0);
    check({"frame_count_", tag}, frame_count, model_cnt);
    check({"busy_idle_", tag}, busy, 0);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [FW-1:0] f;
    int rd0, c;
    repeat (3) @(negedge clk40);
    check("rst_rd", fifo_rd, 0);
    check("rst_start", start_send, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", tx_timeout, 0);
    check("rst_data", data_send, 0);
    reset = 1'b0;
    @(negedge clk40);
    check("rst_count", frame_count, 0);

    // 1: bytes 01..14
    for (int i = 0; i < NB; i++) f[FW-1-8*i -: 8] = 8'(i + 1);
    log_q.delete();
    fifo_q.push_back(f);
    wait_quiet("t1");
    check("t1_nbytes", log_q.size(), WIRE_B);
    for (int i = 0; i < NB; i++) check("t1_byte", log_q[i], i + 1);
    check("t1_count", frame_count, 1);

    // 2: three frames back to back
    rd0 = n_rd;
    log_q.delete();
    repeat (3) fifo_q.push_back(rand_frame());
    wait_quiet("t2");
    check("t2_rd_pulses", n_rd - rd0, 3);
    check("t2_nbytes", log_q.size(), 3 * WIRE_B);
    check("t2_count", frame_count, 4);

    // 3: uart never acks -> timeout, then a normal frame
    uart_mute = 1'b1;
    fifo_q.push_back(rand_frame());
    c = 0;
    while (n_to == 0 && c < 3000) begin @(negedge clk40); c++; end
    check("t3_timeout_seen", n_to, 1);
    uart_mute = 1'b0;
    wait_quiet("t3a");
    check("t3_count_kept", frame_count, 4);
    fifo_q.push_back(rand_frame());
    wait_quiet("t3b");
    check("t3_count_next", frame_count, 5);

    // 4: reset during byte 7
    log_q.delete();
    fifo_q.push_back(rand_frame());
    c = 0;
    while (log_q.size() < 8 && c < 5000) begin @(negedge clk40); c++; end
    check("t4_reached_byte7", log_q.size(), 8);
    rd0 = n_rd;
    reset = 1'b1;
    @(negedge clk40);
    check("t4_start_low", start_send, 0);
    check("t4_busy_low", busy, 0);
    check("t4_rd_low", fifo_rd, 0);
    exp_q.delete();
    model_cnt = 16'h0000;
    reset = 1'b0;
    wait_quiet("t4a");
    check("t4_no_reread", n_rd, rd0);
    f = rand_frame();
    log_q.delete();
    fifo_q.push_back(f);
    wait_quiet("t4b");
    check("t4_first_byte", log_q[0], f[FW-1 -: 8]);
    check("t4_count", frame_count, 1);

    // 5: checksum frame, all A5 except byte0 = 00
    for (int i = 0; i < NB; i++) f[FW-1-8*i -: 8] = (i == 0) ? 8'h00 : 8'hA5;
    log_q.delete();
    fifo_q.push_back(f);
    wait_quiet("t5");
    check("t5_nbytes", log_q.size(), WIRE_B);
`ifdef FRAME_SERIALIZER_CKSUM_EN
    check("t5_cksum", log_q[20], 8'hA5);
`endif

    // 6: frame_count wraps
    force dut.r_frame_count = 16'hFFFF;
    @(negedge clk40);
    release dut.r_frame_count;
    model_cnt = 16'hFFFF;
    @(negedge clk40);
    check("t6_preload", frame_count, 16'hFFFF);
    fifo_q.push_back(rand_frame());
    wait_quiet("t6");
    check("t6_wrap", frame_count, 16'h0000);
    check("t6_no_x", $isunknown({fifo_rd, start_send, data_send, busy, tx_timeout, frame_count}), 0);

    // random traffic with random uart timing
    rand_mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 2)) fifo_q.push_back(rand_frame());
      fifo_q.push_back(rand_frame());
      repeat ($urandom_range(1, 40)) @(negedge clk40);
    end
    wait_quiet("rand");
    check("timeouts_total", n_to, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
